// File: rtl/control_unit_if.sv
// Bus between the microsequencer and the fetch/ALU/register/data-memory side of the datapath.
interface control_unit_if #(
  parameter int unsigned PC_W = 10,
  parameter int unsigned IW   = 24
);
  logic            start;
  logic [IW-1:0]   im_data;
  logic            z_flag;
  logic [PC_W-1:0] im_addr;
  logic [3:0]      ALU_OP;
  logic [3:0]      a_sel;
  logic [3:0]      b_sel;
  logic            b_is_imm;
  logic [18:0]     b_imm;
  logic            wr_en;
  logic [3:0]      wr_sel;
  logic            wr_src;
  logic            dm_rd;
  logic            dm_wr;
  logic            busy;
  logic            done;

  modport master (
    input  start, im_data, z_flag,
    output im_addr, ALU_OP, a_sel, b_sel, b_is_imm, b_imm,
           wr_en, wr_sel, wr_src, dm_rd, dm_wr, busy, done
  );

  modport slave (
    output start, im_data, z_flag,
    input  im_addr, ALU_OP, a_sel, b_sel, b_is_imm, b_imm,
           wr_en, wr_sel, wr_src, dm_rd, dm_wr, busy, done
  );
endinterface

// File: rtl/control_unit.sv
// Non-pipelined microsequencer: fetch, decode, execute, optional memory and writeback phases
// for one 24-bit instruction at a time.
module control_unit #(
  parameter int unsigned PC_W = 10,
  parameter int unsigned IW   = 24
) (
  input logic           clk,
  input logic           RST,
  control_unit_if.master bus
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;

  logic [3:0]  op, rd, rs, rt;
  logic [11:0] imm;
  logic [3:0]  alu_op;
  logic        uses_imm, has_wb, jump_taken, alu_phase;

  assign op  = ir_q[23:20];
  assign rd  = ir_q[19:16];
  assign rs  = ir_q[15:12];
  assign rt  = ir_q[11:8];
  assign imm = ir_q[11:0];

  always_comb begin
    alu_op = 4'h0;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: alu_op = op;
      4'h9, 4'hA, 4'hB:                               alu_op = 4'h9;
      default:                                        alu_op = 4'h0;
    endcase
  end

  assign uses_imm   = (op == 4'h2) || (op == 4'h3) || (op == 4'h6) || (op == 4'h7);
  assign has_wb     = (op >= 4'h1) && (op <= 4'hA);
  assign jump_taken = (op == 4'hC) || ((op == 4'hD) && bus.z_flag) ||
                      ((op == 4'hE) && !bus.z_flag);
  // Operand buses stay stable from EXEC through the last cycle of the instruction.
  assign alu_phase  = (state_q == StExec) || (state_q == StMem) || (state_q == StWb);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (bus.start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      StFetch:  state_d = StDecode;
      StDecode: begin
        ir_d    = bus.im_data;
        state_d = StExec;
      end
      StExec: begin
        pc_d = jump_taken ? ir_q[PC_W-1:0] : pc_q + PC_W'(1);
        if (op == 4'hA)      state_d = StMem;
        else if (has_wb)     state_d = StWb;
        else if (op == 4'hF) state_d = StHalt;
        else                 state_d = StFetch;
      end
      StMem:    state_d = StWb;
      StWb:     state_d = StFetch;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.im_addr  = pc_q;
    bus.ALU_OP   = 4'h0;
    bus.a_sel    = 4'h0;
    bus.b_sel    = 4'h0;
    bus.b_is_imm = 1'b0;
    bus.b_imm    = '0;
    if (alu_phase) begin
      bus.ALU_OP   = alu_op;
      bus.a_sel    = rs;
      bus.b_is_imm = uses_imm;
      bus.b_sel    = uses_imm ? 4'h0 : rt;
      bus.b_imm    = uses_imm ? {7'b0, imm} : 19'h0;
    end
    bus.dm_rd  = (state_q == StExec) && (op == 4'hA);
    bus.dm_wr  = (state_q == StExec) && (op == 4'hB);
    bus.wr_en  = (state_q == StWb);
    bus.wr_sel = (state_q == StWb) ? rd : 4'h0;
    bus.wr_src = (state_q == StWb) && (op == 4'hA);
    bus.busy   = (state_q != StIdle) && (state_q != StHalt);
    bus.done   = (state_q == StHalt);
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomised bench for control_unit: an instruction-level model expands each fetched
// instruction into its expected per-cycle output trace, compared every cycle.
module tb_control_unit;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [9:0]  im_addr;
    logic [3:0]  alu_op;
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic        b_is_imm;
    logic [18:0] b_imm;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic        wr_src;
    logic        dm_rd;
    logic        dm_wr;
  } outs_t;

  typedef struct {
    outs_t o;
    logic  z;
  } rec_t;

  logic clk;
  logic RST;
  control_unit_if #(.PC_W(10), .IW(24)) bus ();

  control_unit #(.PC_W(10), .IW(24)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] imem [1024];
  always @(posedge clk) bus.im_data <= imem[bus.im_addr];

  int    n_checks = 0;
  int    n_err    = 0;
  rec_t  exp_q[$];
  logic [9:0] m_pc;
  logic  m_run, m_done;
  int    z_mode;
  outs_t last_out;
  outs_t log_o [16];

  logic [3:0] alu_tab [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                               4'h8, 4'h9, 4'h9, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0};
  bit imm_op [16] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t s;
    s.busy = bus.busy;     s.done = bus.done;       s.im_addr = bus.im_addr;
    s.alu_op = bus.ALU_OP; s.a_sel = bus.a_sel;     s.b_sel = bus.b_sel;
    s.b_is_imm = bus.b_is_imm; s.b_imm = bus.b_imm; s.wr_en = bus.wr_en;
    s.wr_sel = bus.wr_sel; s.wr_src = bus.wr_src;   s.dm_rd = bus.dm_rd;
    s.dm_wr = bus.dm_wr;
    return s;
  endfunction

  function automatic logic pick_z();
    if (z_mode == 1) return 1'b1;
    if (z_mode == 2) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input outs_t o, input logic z);
    rec_t r;
    r.o = o;
    r.z = z;
    exp_q.push_back(r);
  endtask

  // Expand the instruction at the model PC into its whole cycle trace.
  task automatic gen_instr();
    logic [23:0] ins;
    logic [3:0]  op;
    outs_t       base, ex, al, wb;
    logic        zx, taken;
    logic [9:0]  npc;
    ins  = imem[m_pc];
    op   = ins[23:20];
    base = '0;
    base.busy = 1'b1;
    base.im_addr = m_pc;
    push(base, pick_z());
    push(base, pick_z());
    al = base;
    al.alu_op   = alu_tab[op];
    al.a_sel    = ins[15:12];
    al.b_is_imm = imm_op[op];
    al.b_sel    = imm_op[op] ? 4'h0 : ins[11:8];
    al.b_imm    = imm_op[op] ? {7'b0, ins[11:0]} : 19'h0;
    zx    = pick_z();
    taken = (op == 4'hC) || (op == 4'hD && zx) || (op == 4'hE && !zx);
    npc   = taken ? ins[9:0] : m_pc + 10'd1;
    ex = al;
    ex.dm_rd = (op == 4'hA);
    ex.dm_wr = (op == 4'hB);
    push(ex, zx);
    al.im_addr = npc;
    if (op == 4'hA) push(al, pick_z());
    if (op >= 4'h1 && op <= 4'hA) begin
      wb = al;
      wb.wr_en  = 1'b1;
      wb.wr_sel = ins[19:16];
      wb.wr_src = (op == 4'hA);
      push(wb, pick_z());
    end
    m_pc = npc;
    if (op == 4'hF) begin
      m_run  = 1'b0;
      m_done = 1'b1;
    end
  endtask

  // Called at a falling edge: compare this cycle, then drive inputs for the next edge.
  task automatic step(input logic st);
    outs_t idle;
    logic  was_busy;
    if (exp_q.size() == 0) begin
      if (m_run) gen_instr();
      else begin
        idle = '0;
        idle.done = m_done;
        idle.im_addr = m_pc;
        push(idle, pick_z());
      end
    end
    last_out = sample();
    check("cycle", last_out, exp_q[0].o);
    bus.z_flag = exp_q[0].z;
    was_busy = exp_q[0].o.busy;
    void'(exp_q.pop_front());
    bus.start = st;
    if (st && !was_busy) begin
      m_pc   = '0;
      m_run  = 1'b1;
      m_done = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    #1;
    RST = 1'b0;
    bus.start = 1'b0;
    #1;
    check("reset_outs", sample(), 64'h0);
    exp_q.delete();
    m_pc = '0;
    m_run = 1'b0;
    m_done = 1'b0;
    @(negedge clk);
    RST = 1'b1;
  endtask

  task automatic run_prog(input int n, input int extra_start);
    step(1'b1);
    for (int i = 0; i < n; i++) begin
      step(i == extra_start);
      log_o[i] = last_out;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 24'h0;
    RST = 1'b0;
    bus.start = 1'b0;
    bus.z_flag = 1'b0;
    z_mode = 0;
    m_pc = '0; m_run = 1'b0; m_done = 1'b0;
    @(negedge clk);
    apply_reset();

    // ADDI r1,r0,5 ; HALT
    imem[0] = 24'h210005; imem[1] = 24'hF00000;
    run_prog(8, -1);
    check("addi_exec_op",  log_o[2].alu_op, 4'h2);
    check("addi_exec_imm", log_o[2].b_imm, 19'd5);
    check("addi_wb_hold",  {log_o[3].alu_op, log_o[3].b_imm}, {4'h2, 19'd5});
    check("addi_wb_wr",    {log_o[3].wr_en, log_o[3].wr_sel}, {1'b1, 4'h1});
    check("halt_fetch_pc", log_o[4].im_addr, 10'd1);
    check("halt_exec",     {log_o[6].busy, log_o[6].done}, 2'b10);
    check("halt_done",     {log_o[7].busy, log_o[7].done}, 2'b01);

    // SUBI r2,r1,5 ; JMPZ 0x3F0, taken then not taken
    apply_reset();
    imem[0] = 24'h321005; imem[1] = 24'hD003F0; imem[2] = 24'hF00000;
    imem[10'h3F0] = 24'hF00000;
    z_mode = 1;
    run_prog(8, -1);
    check("subi_exec", {log_o[2].alu_op, log_o[2].a_sel, log_o[2].b_is_imm}, {4'h3, 4'h1, 1'b1});
    check("jmpz_taken", log_o[7].im_addr, 10'h3F0);
    apply_reset();
    z_mode = 2;
    run_prog(8, -1);
    check("jmpz_not_taken", log_o[7].im_addr, 10'h002);
    z_mode = 0;

    // LOAD r3,[r4]
    apply_reset();
    imem[0] = 24'hA34000; imem[1] = 24'hF00000;
    run_prog(6, -1);
    check("load_exec", {log_o[2].dm_rd, log_o[2].alu_op, log_o[2].a_sel}, {1'b1, 4'h9, 4'h4});
    check("load_mem",  {log_o[3].dm_rd, log_o[3].wr_en, log_o[3].alu_op}, {1'b0, 1'b0, 4'h9});
    check("load_wb",   {log_o[4].wr_en, log_o[4].wr_src, log_o[4].wr_sel}, {1'b1, 1'b1, 4'h3});
    check("load_next", {log_o[5].busy, log_o[5].wr_en, log_o[5].im_addr}, {1'b1, 1'b0, 10'd1});

    // STORE [r5],r6
    apply_reset();
    imem[0] = 24'hB05600;
    run_prog(4, -1);
    check("store_exec", {log_o[2].dm_wr, log_o[2].a_sel, log_o[2].b_sel, log_o[2].b_is_imm,
                         log_o[2].wr_en}, {1'b1, 4'h5, 4'h6, 1'b0, 1'b0});
    check("store_next", {log_o[3].dm_wr, log_o[3].wr_en, log_o[3].im_addr}, {1'b0, 1'b0, 10'd1});

    // JMP 0x3FF ; NOP at 0x3FF wraps to 0; start pulsed while busy
    apply_reset();
    imem[0] = 24'hC003FF; imem[10'h3FF] = 24'h000000;
    run_prog(7, 1);
    check("busy_start_ignored", log_o[3].im_addr, 10'h3FF);
    check("pc_wrap", {log_o[6].busy, log_o[6].im_addr}, {1'b1, 10'h000});

    // Reset asserted during the WB of ADDI
    apply_reset();
    imem[0] = 24'h210005;
    run_prog(3, -1);
    check("wb_strobe_before_rst", bus.wr_en, 1'b1);
    apply_reset();

    // Random programs
    for (int i = 0; i < 1024; i++) imem[i] = 24'($urandom);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) apply_reset();
      else step(m_run ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
